// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and entry layout for the hazard scoreboard.
// Entries are packed vectors: {rd, load, rf_le, valid} from MSB to LSB.
package hazard_scoreboard_pkg;

    localparam int FWD_RF    = 0;

    localparam int ENT_VALID = 0;
    localparam int ENT_RF_LE = 1;
    localparam int ENT_LOAD  = 2;
    localparam int ENT_RD    = 3;

    function automatic int ent_width(input int reg_w);
        return reg_w + ENT_RD;
    endfunction

    function automatic int sel_width(input int nstage);
        return $clog2(nstage + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Per-operand priority encoder over the scoreboard entries.
// The youngest (lowest index) matching entry wins.
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int REG_W  = 5,
    parameter int SEL_W  = 2
) (
    input  logic                    en_i,
    input  logic [REG_W-1:0]        rs_i,
    input  logic [NSTAGE-1:0]       vld_i,
    input  logic [NSTAGE-1:0]       rfle_i,
    input  logic [NSTAGE-1:0]       ld_i,
    input  logic [NSTAGE*REG_W-1:0] rd_i,
    output logic [SEL_W-1:0]        sel_o,
    output logic                    is_load_hit_o,
    output logic [SEL_W-1:0]        hit_stage_o
);

    // Scan oldest to youngest so the youngest match is assigned last.
    always_comb begin
        sel_o         = SEL_W'(FWD_RF);
        is_load_hit_o = 1'b0;
        hit_stage_o   = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (en_i && vld_i[k] && rfle_i[k]
                && rd_i[k*REG_W +: REG_W] == rs_i
                && rs_i != '0) begin
                sel_o         = SEL_W'(k + 1);
                is_load_hit_o = ld_i[k];
                hit_stage_o   = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Data-hazard / forwarding controller beside the ID stage.
// Tracks in-flight destinations in a shift-register scoreboard.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSTAGE   = 3,
    parameter int NSRC     = 2,
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    localparam int SEL_W   = sel_width(NSTAGE)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NSRC*REG_W-1:0] ID_RS,
    input  logic [NSRC-1:0]       ID_USE,
    input  logic [REG_W-1:0]      ID_RD,
    input  logic                  ID_RF_LE,
    input  logic                  ID_L,
    input  logic                  FLUSH,
    output logic [NSRC*SEL_W-1:0] FWD_SEL,
    output logic                  LE,
    output logic                  NOP,
    output logic [15:0]           STALL_CNT
);

    localparam int ENT_W = ent_width(REG_W);

    logic [NSTAGE-1:0][ENT_W-1:0] ent_q, ent_d;
    logic [NSTAGE-1:0]            vld, rfle, ld;
    logic [NSTAGE*REG_W-1:0]      rd_flat;
    logic [NSRC-1:0]              ld_hit;
    logic [NSRC*SEL_W-1:0]        hit_stage;
    logic                         hazard;
    logic [15:0]                  stall_cnt_q, stall_cnt_d;

    always_comb begin
        vld     = '0;
        rfle    = '0;
        ld      = '0;
        rd_flat = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            vld[k]  = ent_q[k][ENT_VALID];
            rfle[k] = ent_q[k][ENT_RF_LE];
            ld[k]   = ent_q[k][ENT_LOAD];
            rd_flat[k*REG_W +: REG_W] =
                ent_q[k][ENT_RD +: REG_W];
        end
    end

    for (genvar s = 0; s < NSRC; s++) begin : g_match
        hazard_match #(
            .NSTAGE (NSTAGE),
            .REG_W  (REG_W),
            .SEL_W  (SEL_W)
        ) u_match (
            .en_i          (ID_USE[s]),
            .rs_i          (ID_RS[s*REG_W +: REG_W]),
            .vld_i         (vld),
            .rfle_i        (rfle),
            .ld_i          (ld),
            .rd_i          (rd_flat),
            .sel_o         (FWD_SEL[s*SEL_W +: SEL_W]),
            .is_load_hit_o (ld_hit[s]),
            .hit_stage_o   (hit_stage[s*SEL_W +: SEL_W])
        );
    end

    // Only the winning match counts; an older load behind a younger hit is moot.
    always_comb begin
        hazard = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            if (ld_hit[s]
                && hit_stage[s*SEL_W +: SEL_W] < SEL_W'(LOAD_LAT))
                hazard = 1'b1;
        end
    end

    always_comb begin
        LE  = !(hazard && !FLUSH);
        NOP = hazard || FLUSH;

        ent_d = '0;
        if (LE && !NOP) begin
            ent_d[0][ENT_VALID]        = 1'b1;
            ent_d[0][ENT_RF_LE]        = ID_RF_LE;
            ent_d[0][ENT_LOAD]         = ID_L;
            ent_d[0][ENT_RD +: REG_W]  = ID_RD;
        end
        for (int k = 1; k < NSTAGE; k++)
            ent_d[k] = ent_q[k-1];

        stall_cnt_d = stall_cnt_q;
        if (hazard && !FLUSH && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ent_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            ent_q       <= ent_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized + directed bench for hazard_scoreboard, three configurations
// driven from one input stream and checked against an entry-list model.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  id_rs = '0;
    logic [1:0]  id_use = '0;
    logic [4:0]  id_rd = '0;
    logic        id_rf_le = 1'b0;
    logic        id_l = 1'b0;
    logic        flush = 1'b0;

    logic [3:0]  fs0;
    logic [5:0]  fs1;
    logic [9:0]  fs2;
    logic        le  [3];
    logic        nop [3];
    logic [15:0] cnt [3];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NSTAGE(3), .NSRC(2), .REG_W(5), .LOAD_LAT(1)) d0 (
        .CLK(clk), .RST(rst_n), .ID_RS(id_rs), .ID_USE(id_use),
        .ID_RD(id_rd), .ID_RF_LE(id_rf_le), .ID_L(id_l), .FLUSH(flush),
        .FWD_SEL(fs0), .LE(le[0]), .NOP(nop[0]), .STALL_CNT(cnt[0])
    );

    hazard_scoreboard #(.NSTAGE(4), .NSRC(2), .REG_W(5), .LOAD_LAT(2)) d1 (
        .CLK(clk), .RST(rst_n), .ID_RS(id_rs), .ID_USE(id_use),
        .ID_RD(id_rd), .ID_RF_LE(id_rf_le), .ID_L(id_l), .FLUSH(flush),
        .FWD_SEL(fs1), .LE(le[1]), .NOP(nop[1]), .STALL_CNT(cnt[1])
    );

    hazard_scoreboard #(.NSTAGE(16), .NSRC(2), .REG_W(5), .LOAD_LAT(15)) d2 (
        .CLK(clk), .RST(rst_n), .ID_RS(id_rs), .ID_USE(id_use),
        .ID_RD(id_rd), .ID_RF_LE(id_rf_le), .ID_L(id_l), .FLUSH(flush),
        .FWD_SEL(fs2), .LE(le[2]), .NOP(nop[2]), .STALL_CNT(cnt[2])
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        bit       v;
        bit [4:0] rd;
        bit       rfle;
        bit       ld;
    } ent_t;

    int   ns [3] = '{3, 4, 16};
    int   ll [3] = '{1, 2, 15};
    ent_t sb [3][16];
    int   mcnt [3];

    function automatic int exp_sel(int i, int s);
        int r;
        r = id_rs[s*5 +: 5];
        if (!id_use[s]) return 0;
        for (int k = 0; k < ns[i]; k++)
            if (sb[i][k].v && sb[i][k].rfle
                && sb[i][k].rd == r && r != 0)
                return k + 1;
        return 0;
    endfunction

    function automatic bit exp_haz(int i);
        for (int s = 0; s < 2; s++) begin
            int k;
            k = exp_sel(i, s) - 1;
            if (k >= 0 && sb[i][k].ld && k < ll[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit exp_le(int i);
        return !(exp_haz(i) && !flush);
    endfunction

    function automatic bit exp_nop(int i);
        return exp_haz(i) || flush;
    endfunction

    function automatic ent_t next_ent(int i, int k);
        ent_t e;
        e = '0;
        if (k > 0) return sb[i][k-1];
        if (exp_le(i) && !exp_nop(i)) begin
            e.v = 1'b1; e.rd = id_rd;
            e.rfle = id_rf_le; e.ld = id_l;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                mcnt[i] <= 0;
                for (int k = 0; k < 16; k++) sb[i][k] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (exp_haz(i) && !flush && mcnt[i] < 65535)
                    mcnt[i] <= mcnt[i] + 1;
                for (int k = 0; k < ns[i]; k++)
                    sb[i][k] <= next_ent(i, k);
            end
        end
    end

    function automatic int dut_sel(int i, int s);
        case (i)
            0:       return int'(fs0[s*2 +: 2]);
            1:       return int'(fs1[s*3 +: 3]);
            default: return int'(fs2[s*5 +: 5]);
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)",
                      nm, act, exp_v, $time);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < 2; s++)
                chk($sformatf("d%0d sel%0d", i, s),
                    dut_sel(i, s), exp_sel(i, s));
            chk($sformatf("d%0d le", i), int'(le[i]), int'(exp_le(i)));
            chk($sformatf("d%0d nop", i), int'(nop[i]), int'(exp_nop(i)));
            chk($sformatf("d%0d cnt", i), int'(cnt[i]), mcnt[i]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id(input int rs0, input int rs1, input bit [1:0] u,
                      input int rd, input bit rfle, input bit l);
        id_rs    = {5'(rs1), 5'(rs0)};
        id_use   = u;
        id_rd    = 5'(rd);
        id_rf_le = rfle;
        id_l     = l;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        id(0, 0, 2'b00, 0, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // reset state
        id(0, 0, 2'b00, 0, 1'b0, 1'b0);
        #2;
        chk("rst le", int'(le[0]), 1);
        chk("rst nop", int'(nop[0]), 0);
        chk("rst fwd", int'(fs0), 0);
        chk("rst cnt", int'(cnt[0]), 0);
        do_reset();

        // MEM forward with defaults
        id(0, 0, 2'b00, 3, 1'b1, 1'b0); step();
        id(0, 0, 2'b00, 4, 1'b1, 1'b0); step();
        id(3, 0, 2'b01, 8, 1'b1, 1'b0); #1;
        chk("mem fwd d0", dut_sel(0, 0), 2);
        chk("mem fwd d1", dut_sel(1, 0), 2);
        chk("mem fwd le", int'(le[0]), 1);
        chk("mem fwd nop", int'(nop[0]), 0);
        id_use = 2'b00; #1;
        chk("unused op", dut_sel(0, 0), 0);

        // load-use: 1 stall at LOAD_LAT=1, 2 stalls at LOAD_LAT=2
        do_reset();
        id(0, 0, 2'b00, 5, 1'b1, 1'b1); step();
        id(0, 5, 2'b10, 6, 1'b1, 1'b0); #1;
        chk("lu d0 le", int'(le[0]), 0);
        chk("lu d0 nop", int'(nop[0]), 1);
        chk("lu d0 cnt0", int'(cnt[0]), 0);
        chk("lu d1 le", int'(le[1]), 0);
        step();
        chk("lu d0 rel le", int'(le[0]), 1);
        chk("lu d0 rel nop", int'(nop[0]), 0);
        chk("lu d0 rel sel", dut_sel(0, 1), 2);
        chk("lu d0 cnt1", int'(cnt[0]), 1);
        chk("lu d1 le2", int'(le[1]), 0);
        step();
        chk("lu d1 rel le", int'(le[1]), 1);
        chk("lu d1 rel sel", dut_sel(1, 1), 3);
        chk("lu d1 cnt2", int'(cnt[1]), 2);

        // youngest match wins; GR0 never matches
        do_reset();
        id(0, 0, 2'b00, 7, 1'b1, 1'b0); step();
        id(0, 0, 2'b00, 7, 1'b1, 1'b0); step();
        id(7, 0, 2'b01, 0, 1'b0, 1'b0); #1;
        chk("young d0", dut_sel(0, 0), 1);
        chk("young d1", dut_sel(1, 0), 1);
        do_reset();
        repeat (3) begin id(0, 0, 2'b00, 0, 1'b1, 1'b0); step(); end
        id(0, 0, 2'b11, 0, 1'b0, 1'b0); #1;
        chk("gr0 sel0", dut_sel(0, 0), 0);
        chk("gr0 sel1", dut_sel(0, 1), 0);

        // hazard together with flush
        do_reset();
        id(0, 0, 2'b00, 5, 1'b1, 1'b1); step();
        id(0, 5, 2'b10, 9, 1'b1, 1'b0);
        flush = 1'b1; #1;
        chk("fl le", int'(le[0]), 1);
        chk("fl nop", int'(nop[0]), 1);
        step();
        flush = 1'b0;
        chk("fl cnt", int'(cnt[0]), 0);
        id(9, 5, 2'b11, 10, 1'b0, 1'b0); #1;
        chk("fl no ex fwd", dut_sel(0, 0), 0);
        chk("fl load mem", dut_sel(0, 1), 2);
        chk("fl le2", int'(le[0]), 1);

        // random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            id($urandom_range(0, 7), $urandom_range(0, 7),
               2'($urandom), $urandom_range(0, 7),
               1'($urandom), 1'($urandom));
            flush = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0; #1; rst_n = 1'b1;
            end
            step();
        end

        // saturate STALL_CNT on the long-latency instance
        do_reset();
        id(5, 0, 2'b01, 5, 1'b1, 1'b1);
        for (int c = 0; c < 72000 && mcnt[2] != 65535; c++) step();
        chk("sat reached", mcnt[2], 65535);
        repeat (16) step();
        chk("sat hold", int'(cnt[2]), 65535);

        // reset asserted during a stall
        for (int c = 0; c < 20 && !exp_haz(2); c++) step();
        chk("stall before rst", int'(le[2]), 0);
        #1;
        rst_n = 1'b0; #1;
        chk("rst stall le", int'(le[2]), 1);
        chk("rst stall nop", int'(nop[2]), 0);
        chk("rst stall cnt", int'(cnt[2]), 0);
        chk("rst stall sel", dut_sel(2, 0), 0);
        #1;
        rst_n = 1'b1;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
